// File: rtl/csr_pkg.sv
// Shared CSR widths, capacity and producer FSM states for the block writer, the aggregation
// engine and the buffer modules.
package csr_pkg;

    typedef enum logic [1:0] {StWait, StFill, StPad, StDone} stateT;

    function automatic int unsigned calcIndptrAw(input int unsigned k);
        return $clog2(k + 1);
    endfunction

    function automatic int unsigned calcIndiceAw(input int unsigned k);
        return $clog2(k * k / 32);
    endfunction

    function automatic int unsigned calcIndptrDw(input int unsigned k);
        return calcIndiceAw(k);
    endfunction

    function automatic int unsigned calcIndiceDw(input int unsigned k);
        return $clog2(k);
    endfunction

    // Largest edge count a bank holds; one indice slot is sacrificed so nnz fits the indptr word.
    function automatic int unsigned calcCap(input int unsigned k);
        return (1 << calcIndiceAw(k)) - 1;
    endfunction

    localparam int unsigned DefK        = 1024;
    localparam int unsigned DefIndptrAw = calcIndptrAw(DefK);
    localparam int unsigned DefIndptrDw = calcIndptrDw(DefK);
    localparam int unsigned DefIndiceAw = calcIndiceAw(DefK);
    localparam int unsigned DefIndiceDw = calcIndiceDw(DefK);
    localparam int unsigned DefCap      = calcCap(DefK);

endpackage

// File: rtl/csr_block_writer_if.sv
// Row-sorted edge stream feeding the CSR block writer.
interface csr_block_writer_if
    import csr_pkg::*;
#(
    parameter int unsigned k = 1024
) ();
    localparam int unsigned IndiceDw = calcIndiceDw(k);

    logic                edge_valid;
    logic                edge_ready;
    logic [IndiceDw-1:0] edge_row;
    logic [IndiceDw-1:0] edge_col;
    logic                edge_last;

    modport master (output edge_valid, output edge_row, output edge_col, output edge_last,
                    input edge_ready);
    modport slave (input edge_valid, input edge_row, input edge_col, input edge_last,
                   output edge_ready);

endinterface

// File: rtl/csr_bank_tracker.sv
// Ping-pong bank ownership: which bank is being written and which banks await consumer release.
module csr_bank_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       doneSet,
    input  logic [1:0] bankRelease,
    output logic       wrBank,
    output logic [1:0] bankBusy
);

    logic [1:0] setMask;
    logic [1:0] busyNext;

    // A hand-over and a release of the same bank in one cycle leaves it busy.
    always_comb begin
        setMask = 2'b00;
        if (doneSet) begin
            setMask[wrBank] = 1'b1;
        end
        busyNext = setMask | (bankBusy & ~bankRelease);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrBank   <= 1'b0;
            bankBusy <= 2'b00;
        end else begin
            bankBusy <= busyNext;
            if (doneSet) begin
                wrBank <= ~wrBank;
            end
        end
    end

endmodule

// File: rtl/csr_block_writer.sv
// Producer of CSR blocks: turns a row-sorted edge stream into indptr/indice writes
// into ping-pong banks A/B and hands each finished bank to the consumer.
module csr_block_writer
    import csr_pkg::*;
#(
    parameter int unsigned k = 1024,
    localparam int unsigned IndptrAw = calcIndptrAw(k),
    localparam int unsigned IndptrDw = calcIndptrDw(k),
    localparam int unsigned IndiceAw = calcIndiceAw(k),
    localparam int unsigned IndiceDw = calcIndiceDw(k),
    localparam int unsigned Cap      = calcCap(k)
) (
    input  logic                 clk,
    input  logic                 rst,
    csr_block_writer_if.slave    edgeIf,
    input  logic [1:0]           bank_release,
    output logic                 indptr_we_a,
    output logic                 indptr_we_b,
    output logic [IndptrAw-1:0]  indptr_addr,
    output logic [IndptrDw-1:0]  indptr_wdata,
    output logic                 indice_we_a,
    output logic                 indice_we_b,
    output logic [IndiceAw-1:0]  indice_addr,
    output logic [IndiceDw-1:0]  indice_wdata,
    output logic                 block_done,
    output logic                 done_bank,
    output logic [IndptrDw-1:0]  done_nnz,
    output logic                 err_order,
    output logic                 err_overflow
);

    stateT               state, stateNext;
    logic [IndptrDw-1:0] nnz, nnzNext;
    logic [IndptrAw:0]   ptrRow, ptrRowNext, rowExt;
    logic                errOrder, errOverflow, setOrder, setOverflow;
    logic                indptrWr, indiceWr, doneSet, ready;
    logic                wrBank;
    logic [1:0]          bankBusy;

    csr_bank_tracker u_bank_tracker (
        .clk         (clk),
        .rst         (rst),
        .doneSet     (doneSet),
        .bankRelease (bank_release),
        .wrBank      (wrBank),
        .bankBusy    (bankBusy)
    );

    assign rowExt = (IndptrAw + 1)'(edgeIf.edge_row);

    always_comb begin
        stateNext   = state;
        nnzNext     = nnz;
        ptrRowNext  = ptrRow;
        ready       = 1'b0;
        indptrWr    = 1'b0;
        indiceWr    = 1'b0;
        setOrder    = 1'b0;
        setOverflow = 1'b0;
        doneSet     = 1'b0;
        unique case (state)
            StWait: begin
                if (!bankBusy[wrBank]) begin
                    stateNext = StFill;
                end
            end
            StFill: begin
                if (edgeIf.edge_valid) begin
                    // Close every row up to the edge's row before the edge itself is taken.
                    if (rowExt >= ptrRow) begin
                        indptrWr   = 1'b1;
                        ptrRowNext = ptrRow + (IndptrAw + 1)'(1);
                    end else begin
                        ready = 1'b1;
                        if ((rowExt + (IndptrAw + 1)'(1)) < ptrRow) begin
                            setOrder = 1'b1;
                        end else if (nnz == IndptrDw'(Cap)) begin
                            setOverflow = 1'b1;
                        end else begin
                            indiceWr = 1'b1;
                            nnzNext  = nnz + IndptrDw'(1);
                        end
                        if (edgeIf.edge_last) begin
                            stateNext = StPad;
                        end
                    end
                end
            end
            StPad: begin
                indptrWr   = 1'b1;
                ptrRowNext = ptrRow + (IndptrAw + 1)'(1);
                if (ptrRow == (IndptrAw + 1)'(k)) begin
                    stateNext = StDone;
                end
            end
            StDone: begin
                doneSet    = 1'b1;
                nnzNext    = '0;
                ptrRowNext = '0;
                stateNext  = StWait;
            end
            default: stateNext = StWait;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StWait;
            nnz         <= '0;
            ptrRow      <= '0;
            errOrder    <= 1'b0;
            errOverflow <= 1'b0;
        end else begin
            state       <= stateNext;
            nnz         <= nnzNext;
            ptrRow      <= ptrRowNext;
            errOrder    <= errOrder | setOrder;
            errOverflow <= errOverflow | setOverflow;
        end
    end

    assign edgeIf.edge_ready = ready;
    assign indptr_we_a       = indptrWr & ~wrBank;
    assign indptr_we_b       = indptrWr & wrBank;
    assign indice_we_a       = indiceWr & ~wrBank;
    assign indice_we_b       = indiceWr & wrBank;
    assign indptr_addr       = ptrRow[IndptrAw-1:0];
    assign indptr_wdata      = nnz;
    assign indice_addr       = nnz;
    assign indice_wdata      = (state == StFill) ? edgeIf.edge_col : '0;
    assign block_done        = doneSet;
    assign done_bank         = doneSet & wrBank;
    assign done_nnz          = doneSet ? nnz : '0;
    assign err_order         = errOrder;
    assign err_overflow      = errOverflow;

endmodule
